// File: rtl/slc3_mem_bridge.sv
// SLC-3 memory bridge: sequences MAR/MDR requests into async-SRAM pin cycles plus one I/O address.
// Optional byte-lane support is enabled by defining SRAM_BYTE_LANE_EN.
module slc3_mem_bridge #(
  parameter int unsigned       ADDR_W  = 20,
  parameter int unsigned       DATA_W  = 16,
  parameter int unsigned       RD_WAIT = 2,
  parameter int unsigned       WR_WAIT = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR = 'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef SRAM_BYTE_LANE_EN
  input  logic [1:0]        req_be,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic [DATA_W-1:0] Switches,
  output logic [DATA_W-1:0] hex_data,
  output logic              CE_N,
  output logic              OE_N,
  output logic              WE_N,
  output logic              UB_N,
  output logic              LB_N,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in
);

  typedef enum logic [2:0] {StIdle, StRd, StWs, StWp, StWh, StIo, StRsp} state_e;

  localparam logic [3:0] RdLoad = 4'(RD_WAIT - 1);
  localparam logic [3:0] WrLoad = 4'(WR_WAIT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [DATA_W-1:0] io_wdata_q;
  logic              accept;
  logic              is_io;
`ifdef SRAM_BYTE_LANE_EN
  logic [1:0]        be_q;
`endif

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;
  // Full-width compare: any set bit above the I/O address width forces an SRAM access.
  assign is_io     = (req_addr == IO_ADDR);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_io)       state_d = StIo;
          else if (req_we) state_d = StWs;
          else             state_d = StRd;
        end
      end
      StRd:    if (cnt_q == 4'd0) state_d = StRsp;
      StWs:    state_d = StWp;
      StWp:    if (cnt_q == 4'd0) state_d = StWh;
      StWh:    state_d = StRsp;
      StIo:    state_d = StRsp;
      StRsp:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    CE_N       = 1'b1;
    OE_N       = 1'b1;
    WE_N       = 1'b1;
    UB_N       = 1'b1;
    LB_N       = 1'b1;
    sram_dq_oe = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state_q)
      StRd: begin
        CE_N = 1'b0;
        OE_N = 1'b0;
      end
      StWs, StWh: begin
        CE_N       = 1'b0;
        sram_dq_oe = 1'b1;
      end
      StWp: begin
        CE_N       = 1'b0;
        sram_dq_oe = 1'b1;
`ifdef SRAM_BYTE_LANE_EN
        // A write with no lanes enabled keeps its timing but never strobes WE_N.
        WE_N       = (be_q == 2'b00);
`else
        WE_N       = 1'b0;
`endif
      end
      StRsp:   rsp_valid = 1'b1;
      default: ;
    endcase
`ifdef SRAM_BYTE_LANE_EN
    if (state_q == StRd) begin
      UB_N = 1'b0;
      LB_N = 1'b0;
    end else if (state_q inside {StWs, StWp, StWh}) begin
      UB_N = ~be_q[1];
      LB_N = ~be_q[0];
    end
`else
    UB_N = CE_N;
    LB_N = CE_N;
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      io_wdata_q  <= '0;
      rsp_rdata   <= '0;
      hex_data    <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
`ifdef SRAM_BYTE_LANE_EN
      be_q        <= 2'b00;
`endif
    end else begin
      if (accept) begin
        we_q       <= req_we;
        io_wdata_q <= req_wdata;
        cnt_q      <= RdLoad;
`ifdef SRAM_BYTE_LANE_EN
        be_q       <= req_be;
`endif
        // I/O accesses leave the SRAM pins untouched.
        if (!is_io) begin
          sram_addr <= req_addr;
          if (req_we) sram_dq_out <= req_wdata;
        end
      end
      if (state_q == StWs) cnt_q <= WrLoad;
      if ((state_q == StRd || state_q == StWp) && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      if (state_q == StRd && cnt_q == 4'd0) rsp_rdata <= sram_dq_in;
      if (state_q == StIo) begin
        if (we_q) hex_data  <= io_wdata_q;
        else      rsp_rdata <= Switches;
      end
    end
  end

endmodule

// File: tb/tb_slc3_mem_bridge.sv
// Bench for slc3_mem_bridge: cycle-offset reference model checked every negedge plus directed
// literal checks. Byte-lane cases are built when SRAM_BYTE_LANE_EN is defined.
module tb_slc3_mem_bridge;

  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned RD_WAIT = 2;
  localparam int unsigned WR_WAIT = 2;
  localparam int KNone = 0, KRd = 1, KWr = 2, KIo = 3;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata, Switches, hex_data;
  logic              CE_N, OE_N, WE_N, UB_N, LB_N;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_out, sram_dq_in;
  logic              sram_dq_oe;

  int n_cmp = 0;
  int n_err = 0;

  slc3_mem_bridge #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_WAIT(RD_WAIT),
    .WR_WAIT(WR_WAIT),
    .IO_ADDR(20'hFFFF)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef SRAM_BYTE_LANE_EN
    .req_be     (be),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .Switches   (Switches),
    .hex_data   (hex_data),
    .CE_N       (CE_N),
    .OE_N       (OE_N),
    .WE_N       (WE_N),
    .UB_N       (UB_N),
    .LB_N       (LB_N),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction kind plus cycle offset k since the accepting edge (k=1 first).
  int                m_kind = KNone;
  int                m_k = 0;
  logic              m_we;
  logic [DATA_W-1:0] m_wdata;
  logic [1:0]        m_be;
  logic [DATA_W-1:0] e_rdata, e_hex, e_dq;
  logic [ADDR_W-1:0] e_addr;

  function automatic int total_of(input int kind);
    case (kind)
      KRd:     return RD_WAIT + 1;
      KWr:     return WR_WAIT + 3;
      KIo:     return 2;
      default: return 0;
    endcase
  endfunction

  initial begin
    forever begin
      logic x_ce, x_oe, x_we, x_ub, x_lb, x_doe, x_rv;
      @(negedge Clk);
      if (Reset) begin
        m_kind = KNone; m_k = 0;
        e_rdata = '0; e_hex = '0; e_dq = '0; e_addr = '0;
      end
      x_ce = 1; x_oe = 1; x_we = 1; x_ub = 1; x_lb = 1; x_doe = 0; x_rv = 0;
      if (m_kind == KRd) begin
        if (m_k <= RD_WAIT) begin x_ce = 0; x_oe = 0; x_ub = 0; x_lb = 0; end
      end else if (m_kind == KWr) begin
        if (m_k <= WR_WAIT + 2) begin
          x_ce = 0; x_doe = 1;
`ifdef SRAM_BYTE_LANE_EN
          x_ub = ~m_be[1]; x_lb = ~m_be[0];
`else
          x_ub = 0; x_lb = 0;
`endif
        end
        if (m_k >= 2 && m_k <= WR_WAIT + 1) begin
`ifdef SRAM_BYTE_LANE_EN
          x_we = (m_be == 2'b00);
`else
          x_we = 0;
`endif
        end
      end
      if (m_kind != KNone && m_k == total_of(m_kind)) x_rv = 1;
      chk("req_ready", 32'(req_ready), (m_kind == KNone) ? 1 : 0);
      chk("rsp_valid", 32'(rsp_valid), 32'(x_rv));
      chk("CE_N", 32'(CE_N), 32'(x_ce));
      chk("OE_N", 32'(OE_N), 32'(x_oe));
      chk("WE_N", 32'(WE_N), 32'(x_we));
      chk("UB_N", 32'(UB_N), 32'(x_ub));
      chk("LB_N", 32'(LB_N), 32'(x_lb));
      chk("sram_dq_oe", 32'(sram_dq_oe), 32'(x_doe));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
      chk("hex_data", 32'(hex_data), 32'(e_hex));
      chk("sram_addr", 32'(sram_addr), 32'(e_addr));
      chk("sram_dq_out", 32'(sram_dq_out), 32'(e_dq));
      if (!Reset) begin
        // Predict the upcoming edge from inputs that stay stable until then.
        if (m_kind != KNone) begin
          if (m_kind == KRd && m_k == RD_WAIT) e_rdata = sram_dq_in;
          if (m_kind == KIo && m_k == 1) begin
            if (m_we) e_hex = m_wdata;
            else      e_rdata = Switches;
          end
          if (m_k == total_of(m_kind)) m_kind = KNone;
          else                         m_k++;
        end else if (req_valid) begin
          m_we = req_we; m_wdata = req_wdata; m_be = be; m_k = 1;
          if (req_addr == 20'hFFFF) m_kind = KIo;
          else begin
            m_kind = req_we ? KWr : KRd;
            e_addr = req_addr;
            if (req_we) e_dq = req_wdata;
          end
        end
      end
    end
  end

  // Issues one request and returns 1 time unit after its accepting edge (inside cycle 1).
  task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [1:0] bev);
    logic was_ready;
    bit   ok;
    ok = 0;
    @(posedge Clk); #1;
    req_we = we; req_addr = addr; req_wdata = wdata; be = bev; req_valid = 1;
    for (int i = 0; i < 50; i++) begin
      was_ready = req_ready;
      @(posedge Clk); #1;
      if (was_ready) begin ok = 1; break; end
    end
    req_valid = 0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  // Counts pin activity per cycle until rsp_valid; leaves at the response cycle's negedge.
  task automatic measure(output int ce_lo, output int oe_lo, output int we_lo, output int doe,
                         output int ub_lo, output int lb_lo, output int rsp_cyc,
                         output logic [DATA_W-1:0] rd);
    ce_lo = 0; oe_lo = 0; we_lo = 0; doe = 0; ub_lo = 0; lb_lo = 0; rsp_cyc = 0; rd = '0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge Clk);
      if (!CE_N) ce_lo++;
      if (!OE_N) oe_lo++;
      if (!WE_N) we_lo++;
      if (sram_dq_oe) doe++;
      if (!UB_N) ub_lo++;
      if (!LB_N) lb_lo++;
      if (rsp_valid) begin rsp_cyc = c; rd = rsp_rdata; break; end
    end
    if (rsp_cyc == 0) chk("rsp_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ce_lo, oe_lo, we_lo, doe, ub_lo, lb_lo, rsp_cyc, nrsp;
    logic [DATA_W-1:0] rd;
    Reset = 0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; be = 2'b11;
    Switches = '0; sram_dq_in = '0;
    #2 Reset = 1;
    repeat (3) @(posedge Clk);
    #1 Reset = 0;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_ctrl", 32'({CE_N, OE_N, WE_N, UB_N, LB_N}), 'h1F);
    chk("rst_hex", 32'(hex_data), 0);
    chk("rst_rsp", 32'(rsp_valid), 0);

    sram_dq_in = 'h1234;
    do_req(0, 'h0030, '0, 2'b11);
    measure(ce_lo, oe_lo, we_lo, doe, ub_lo, lb_lo, rsp_cyc, rd);
    chk("rd_oe_low", 32'(oe_lo), 2);
    chk("rd_rsp_cycle", 32'(rsp_cyc), 3);
    chk("rd_data", 32'(rd), 'h1234);
    chk("rd_we_low", 32'(we_lo), 0);

    do_req(1, 'h0031, 'hBEEF, 2'b11);
    measure(ce_lo, oe_lo, we_lo, doe, ub_lo, lb_lo, rsp_cyc, rd);
    chk("wr_we_low", 32'(we_lo), 2);
    chk("wr_dq_oe", 32'(doe), 4);
    chk("wr_rsp_cycle", 32'(rsp_cyc), 5);
    chk("wr_oe_low", 32'(oe_lo), 0);
    chk("wr_addr", 32'(sram_addr), 'h0031);
    chk("wr_dq", 32'(sram_dq_out), 'hBEEF);

    do_req(1, 'hFFFF, 'h00A5, 2'b11);
    measure(ce_lo, oe_lo, we_lo, doe, ub_lo, lb_lo, rsp_cyc, rd);
    chk("iow_rsp_cycle", 32'(rsp_cyc), 2);
    chk("iow_ce_low", 32'(ce_lo), 0);
    chk("iow_dq_oe", 32'(doe), 0);
    chk("iow_hex", 32'(hex_data), 'h00A5);
    chk("iow_dq_out", 32'(sram_dq_out), 'hBEEF);

    Switches = 'h0F0F;
    do_req(0, 'hFFFF, '0, 2'b11);
    measure(ce_lo, oe_lo, we_lo, doe, ub_lo, lb_lo, rsp_cyc, rd);
    chk("ior_rsp_cycle", 32'(rsp_cyc), 2);
    chk("ior_data", 32'(rd), 'h0F0F);

    // Upper address bit set: must be a plain SRAM read, not I/O.
    sram_dq_in = 'h5A5A;
    do_req(0, 'h1FFFF, '0, 2'b11);
    measure(ce_lo, oe_lo, we_lo, doe, ub_lo, lb_lo, rsp_cyc, rd);
    chk("hi_rsp_cycle", 32'(rsp_cyc), 3);
    chk("hi_oe_low", 32'(oe_lo), 2);
    chk("hi_data", 32'(rd), 'h5A5A);

    // req_valid held: two reads, each 3 cycles, separated by one idle cycle.
    @(posedge Clk); #1;
    req_we = 0; req_addr = 'h0040; req_valid = 1; sram_dq_in = 'h7777;
    nrsp = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      if (rsp_valid) nrsp++;
    end
    @(posedge Clk); #1 req_valid = 0;
    chk("b2b_rsp_count", 32'(nrsp), 2);
    repeat (3) @(posedge Clk);

    do_req(1, 'h0050, 'hCAFE, 2'b11);
    @(posedge Clk); #1;
    chk("wp_we_low", 32'(WE_N), 0);
    Reset = 1; #1;
    chk("rst_we_n", 32'(WE_N), 1);
    chk("rst_dq_oe", 32'(sram_dq_oe), 0);
    chk("rst_ce_n", 32'(CE_N), 1);
    @(negedge Clk);
    @(posedge Clk); #1 Reset = 0;
    chk("post_rst_ready", 32'(req_ready), 1);
    nrsp = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      if (rsp_valid) nrsp++;
    end
    chk("post_rst_no_rsp", 32'(nrsp), 0);

`ifdef SRAM_BYTE_LANE_EN
    do_req(1, 'h0060, 'h00AB, 2'b01);
    measure(ce_lo, oe_lo, we_lo, doe, ub_lo, lb_lo, rsp_cyc, rd);
    chk("be01_lb_low", 32'(lb_lo), 4);
    chk("be01_ub_low", 32'(ub_lo), 0);
    chk("be01_we_low", 32'(we_lo), 2);
    do_req(1, 'h0061, 'h1111, 2'b00);
    measure(ce_lo, oe_lo, we_lo, doe, ub_lo, lb_lo, rsp_cyc, rd);
    chk("be00_we_low", 32'(we_lo), 0);
    chk("be00_rsp_cycle", 32'(rsp_cyc), 5);
`endif

    repeat (3) @(posedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
